// File: rtl/score_keeper.sv
// ---------------------------------------------------------------------------
// score_keeper
//
// Game score accumulator feeding the on-screen score display. Single-cycle
// gameplay event pulses (pellet, energizer, ghost chain, fruit) are converted
// into a point increment in stage 1. That increment is added to the running
// score, with saturation, in stage 2. The session high score trails the score
// by one further cycle. A one-shot extra-life pulse fires the first time the
// score reaches the award threshold.
//
// Ports
//   Clk           in   1   system clock, rising edge
//   Reset         in   1   asynchronous active-high, clears everything
//   new_game      in   1   sync clear of score/combo/pipeline, hi_score kept
//   pellet_eaten  in   1   pellet consumed
//   power_eaten   in   1   energizer consumed, restarts ghost chain
//   ghost_eaten   in   1   frightened ghost consumed
//   fright_end    in   1   fright period over, chain ends
//   fruit_eaten   in   1   fruit consumed
//   fruit_pts     in   12  fruit value, sampled with fruit_eaten
//   score         out  20  current score (binary)
//   hi_score      out  20  highest score since Reset
//   ghost_idx     out  2   combo index used by the most recent ghost
//   extra_life    out  1   one-cycle pulse on first reaching the threshold
//   score_changed out  1   one-cycle pulse whenever score is updated
// ---------------------------------------------------------------------------
module score_keeper #(
    parameter int unsigned PELLET_PTS     = 10,
    parameter int unsigned POWER_PTS      = 50,
    parameter int unsigned GHOST_BASE     = 200,
    parameter int unsigned EXTRA_LIFE_PTS = 10000,
    parameter int unsigned SCORE_MAX      = 999990
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        new_game,
    input  logic        pellet_eaten,
    input  logic        power_eaten,
    input  logic        ghost_eaten,
    input  logic        fright_end,
    input  logic        fruit_eaten,
    input  logic [11:0] fruit_pts,
    output logic [19:0] score,
    output logic [19:0] hi_score,
    output logic [1:0]  ghost_idx,
    output logic        extra_life,
    output logic        score_changed
);

    // Combo index of the current fright chain and the award flag.
    logic [1:0]  idx;
    logic        awarded;

    // Stage-1 pipeline registers.
    logic [12:0] add_r;
    logic        valid_r;

    // Combinational helpers.
    logic [1:0]  idx_used;
    logic [1:0]  idx_next;
    logic [12:0] ghost_val;
    logic [12:0] add_next;
    logic        any_event;
    logic [20:0] sum_wide;
    logic [19:0] sum_sat;
    logic        award_now;

    // Stage-1 arithmetic and combo bookkeeping. An energizer in the same
    // cycle as a ghost means the ghost belongs to the new chain, so it is
    // valued at index 0. The worst-case sum (10+50+1600+4095) fits in 13 bits.
    always_comb begin
        idx_used  = power_eaten ? 2'd0 : idx;
        idx_next  = idx;
        if (power_eaten) begin
            idx_next = ghost_eaten ? 2'd1 : 2'd0;
        end else if (fright_end) begin
            idx_next = 2'd0;
        end else if (ghost_eaten) begin
            idx_next = (idx == 2'd3) ? 2'd3 : idx + 2'd1;
        end

        ghost_val = 13'(GHOST_BASE) << idx_used;
        add_next  = (pellet_eaten ? 13'(PELLET_PTS) : 13'd0)
                  + (power_eaten  ? 13'(POWER_PTS)  : 13'd0)
                  + (ghost_eaten  ? ghost_val       : 13'd0)
                  + (fruit_eaten  ? {1'b0, fruit_pts} : 13'd0);
        any_event = pellet_eaten | power_eaten | ghost_eaten
                  | fright_end   | fruit_eaten;
    end

    // Stage-2 arithmetic: the sum is formed one bit wider than the score so
    // an overflowing add still compares correctly against the ceiling.
    always_comb begin
        sum_wide  = {1'b0, score} + 21'(add_r);
        sum_sat   = (sum_wide > 21'(SCORE_MAX)) ? 20'(SCORE_MAX) : sum_wide[19:0];
        award_now = valid_r && !awarded && (sum_sat >= 20'(EXTRA_LIFE_PTS));
    end

    // Stage 1 register plus combo index. new_game wins over any event in
    // the same cycle and flushes the increment already waiting in add_r.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            idx       <= 2'd0;
            ghost_idx <= 2'd0;
            add_r     <= 13'd0;
            valid_r   <= 1'b0;
        end else if (new_game) begin
            idx       <= 2'd0;
            ghost_idx <= 2'd0;
            add_r     <= 13'd0;
            valid_r   <= 1'b0;
        end else begin
            idx     <= idx_next;
            add_r   <= add_next;
            valid_r <= any_event;
            if (ghost_eaten) begin
                ghost_idx <= idx_used;
            end
        end
    end

    // Stage 2: accumulate with saturation. score_changed pulses on every
    // valid increment, including zero-point and saturated ones, so the
    // display always sees activity. extra_life fires once per game.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            score         <= 20'd0;
            score_changed <= 1'b0;
            extra_life    <= 1'b0;
            awarded       <= 1'b0;
        end else if (new_game) begin
            score         <= 20'd0;
            score_changed <= 1'b0;
            extra_life    <= 1'b0;
            awarded       <= 1'b0;
        end else begin
            score_changed <= valid_r;
            extra_life    <= award_now;
            if (valid_r) begin
                score <= sum_sat;
            end
            if (award_now) begin
                awarded <= 1'b1;
            end
        end
    end

    // High score trails the registered score by one cycle. It is only ever
    // raised, so new_game leaves it alone and only Reset clears it.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            hi_score <= 20'd0;
        end else if (score > hi_score) begin
            hi_score <= score;
        end
    end

endmodule

// File: tb/tb_score_keeper.sv
// ---------------------------------------------------------------------------
// tb_score_keeper
//
// Directed testbench for score_keeper. Inputs change on the falling edge and
// outputs are sampled on the falling edge, half a cycle away from the active
// edge. Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_score_keeper;

    logic        Clk;
    logic        Reset;
    logic        new_game;
    logic        pellet_eaten;
    logic        power_eaten;
    logic        ghost_eaten;
    logic        fright_end;
    logic        fruit_eaten;
    logic [11:0] fruit_pts;
    logic [19:0] score;
    logic [19:0] hi_score;
    logic [1:0]  ghost_idx;
    logic        extra_life;
    logic        score_changed;

    int vectors;
    int miscompares;

    // Event bit positions for applyStimulus.
    localparam logic [5:0] EV_NEW    = 6'b100000;
    localparam logic [5:0] EV_PELLET = 6'b010000;
    localparam logic [5:0] EV_POWER  = 6'b001000;
    localparam logic [5:0] EV_GHOST  = 6'b000100;
    localparam logic [5:0] EV_FRIGHT = 6'b000010;
    localparam logic [5:0] EV_FRUIT  = 6'b000001;

    score_keeper dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .new_game      (new_game),
        .pellet_eaten  (pellet_eaten),
        .power_eaten   (power_eaten),
        .ghost_eaten   (ghost_eaten),
        .fright_end    (fright_end),
        .fruit_eaten   (fruit_eaten),
        .fruit_pts     (fruit_pts),
        .score         (score),
        .hi_score      (hi_score),
        .ghost_idx     (ghost_idx),
        .extra_life    (extra_life),
        .score_changed (score_changed)
    );

    // 10-unit clock period.
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Compare one observed value against its expected value and count it.
    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle of event pulses starting at a falling edge; returns at
    // the next falling edge with the inputs idle again.
    task automatic applyStimulus(input logic [5:0] ev, input logic [11:0] fp);
        new_game     = ev[5];
        pellet_eaten = ev[4];
        power_eaten  = ev[3];
        ghost_eaten  = ev[2];
        fright_end   = ev[1];
        fruit_eaten  = ev[0];
        fruit_pts    = fp;
        @(negedge Clk);
        new_game     = 1'b0;
        pellet_eaten = 1'b0;
        power_eaten  = 1'b0;
        ghost_eaten  = 1'b0;
        fright_end   = 1'b0;
        fruit_eaten  = 1'b0;
        fruit_pts    = 12'd0;
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        Reset        = 1'b1;
        new_game     = 1'b0;
        pellet_eaten = 1'b0;
        power_eaten  = 1'b0;
        ghost_eaten  = 1'b0;
        fright_end   = 1'b0;
        fruit_eaten  = 1'b0;
        fruit_pts    = 12'd0;
        repeat (2) @(negedge Clk);
        checkOutput("rst_score", 32'(score), 32'd0);
        checkOutput("rst_hi", 32'(hi_score), 32'd0);
        checkOutput("rst_idx", 32'(ghost_idx), 32'd0);
        checkOutput("rst_changed", 32'(score_changed), 32'd0);
        checkOutput("rst_extra", 32'(extra_life), 32'd0);
        Reset = 1'b0;
        @(negedge Clk);

        // Single pellet: score appears two rising edges later.
        applyStimulus(EV_PELLET, 12'd0);
        checkOutput("pel_latency", 32'(score), 32'd0);
        checkOutput("pel_nochg", 32'(score_changed), 32'd0);
        @(negedge Clk);
        checkOutput("pel_score", 32'(score), 32'd10);
        checkOutput("pel_changed", 32'(score_changed), 32'd1);
        @(negedge Clk);
        checkOutput("pel_chg_off", 32'(score_changed), 32'd0);
        checkOutput("pel_hi", 32'(hi_score), 32'd10);

        // Zero-point fruit still pulses score_changed.
        applyStimulus(EV_FRUIT, 12'd0);
        @(negedge Clk);
        checkOutput("fruit0_chg", 32'(score_changed), 32'd1);
        checkOutput("fruit0_score", 32'(score), 32'd10);

        // Energizer then five ghosts: 50+200+400+800+1600+1600.
        applyStimulus(EV_NEW, 12'd0);
        checkOutput("ng_score", 32'(score), 32'd0);
        checkOutput("ng_hi", 32'(hi_score), 32'd10);
        applyStimulus(EV_POWER, 12'd0);
        for (int i = 0; i < 5; i++) applyStimulus(EV_GHOST, 12'd0);
        @(negedge Clk);
        checkOutput("chain_score", 32'(score), 32'd4650);
        checkOutput("chain_idx", 32'(ghost_idx), 32'd3);

        // All events at once: 10+50+200+100, chain restarts at index 1.
        applyStimulus(EV_PELLET | EV_POWER | EV_GHOST | EV_FRUIT, 12'd100);
        @(negedge Clk);
        checkOutput("combo_score", 32'(score), 32'd5010);
        checkOutput("combo_idx", 32'(ghost_idx), 32'd0);
        applyStimulus(EV_GHOST, 12'd0);
        @(negedge Clk);
        checkOutput("after_combo_score", 32'(score), 32'd5410);
        checkOutput("after_combo_idx", 32'(ghost_idx), 32'd1);
        // Ghost with fright_end uses the current index (2 -> 800) then resets.
        applyStimulus(EV_FRIGHT | EV_GHOST, 12'd0);
        @(negedge Clk);
        checkOutput("fright_score", 32'(score), 32'd6210);
        checkOutput("fright_idx", 32'(ghost_idx), 32'd2);
        applyStimulus(EV_GHOST, 12'd0);
        @(negedge Clk);
        checkOutput("post_fright_score", 32'(score), 32'd6410);
        checkOutput("post_fright_idx", 32'(ghost_idx), 32'd0);

        // Extra life crossing at exactly 10000, one shot only.
        applyStimulus(EV_NEW, 12'd0);
        applyStimulus(EV_FRUIT, 12'd4095);
        applyStimulus(EV_FRUIT, 12'd4095);
        applyStimulus(EV_FRUIT, 12'd1800);
        @(negedge Clk);
        checkOutput("xl_pre_score", 32'(score), 32'd9990);
        checkOutput("xl_pre_pulse", 32'(extra_life), 32'd0);
        applyStimulus(EV_PELLET, 12'd0);
        @(negedge Clk);
        checkOutput("xl_score", 32'(score), 32'd10000);
        checkOutput("xl_pulse", 32'(extra_life), 32'd1);
        @(negedge Clk);
        checkOutput("xl_pulse_off", 32'(extra_life), 32'd0);
        applyStimulus(EV_PELLET, 12'd0);
        @(negedge Clk);
        checkOutput("xl_again_score", 32'(score), 32'd10010);
        checkOutput("xl_again_pulse", 32'(extra_life), 32'd0);

        // Ramp to 999980 (244*4095 + 800), then saturate at 999990.
        applyStimulus(EV_NEW, 12'd0);
        for (int i = 0; i < 244; i++) applyStimulus(EV_FRUIT, 12'd4095);
        applyStimulus(EV_FRUIT, 12'd800);
        @(negedge Clk);
        checkOutput("ramp_score", 32'(score), 32'd999980);
        applyStimulus(EV_FRUIT, 12'd4095);
        @(negedge Clk);
        checkOutput("sat_score", 32'(score), 32'd999990);
        checkOutput("sat_changed", 32'(score_changed), 32'd1);
        @(negedge Clk);
        checkOutput("sat_hi", 32'(hi_score), 32'd999990);
        applyStimulus(EV_PELLET, 12'd0);
        @(negedge Clk);
        checkOutput("sat_hold_score", 32'(score), 32'd999990);
        checkOutput("sat_hold_chg", 32'(score_changed), 32'd1);

        // new_game discards an in-flight increment and keeps hi_score.
        applyStimulus(EV_PELLET, 12'd0);
        applyStimulus(EV_NEW, 12'd0);
        @(negedge Clk);
        @(negedge Clk);
        checkOutput("flush_score", 32'(score), 32'd0);
        checkOutput("flush_chg", 32'(score_changed), 32'd0);
        checkOutput("flush_hi", 32'(hi_score), 32'd999990);
        // Events in the same cycle as new_game are ignored.
        applyStimulus(EV_NEW | EV_PELLET, 12'd0);
        @(negedge Clk);
        @(negedge Clk);
        checkOutput("ng_same_score", 32'(score), 32'd0);

        // Asynchronous reset with an increment in flight.
        applyStimulus(EV_PELLET, 12'd0);
        @(negedge Clk);
        checkOutput("pre_rst_score", 32'(score), 32'd10);
        applyStimulus(EV_FRUIT, 12'd300);
        #2 Reset = 1'b1;
        #1;
        checkOutput("arst_score", 32'(score), 32'd0);
        checkOutput("arst_hi", 32'(hi_score), 32'd0);
        checkOutput("arst_chg", 32'(score_changed), 32'd0);
        @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        checkOutput("arst_late_score", 32'(score), 32'd0);
        checkOutput("arst_late_chg", 32'(score_changed), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
